// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared state encoding and default timing constants for the LIF stimulus sequencer
package lif_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NRST  = 3'd1,
      ST_LEAD  = 3'd2,
      ST_PAR   = 3'd3,
      ST_INIT  = 3'd4,
      ST_RUN   = 3'd5,
      ST_DRAIN = 3'd6
   } lif_state_e;

   localparam int DEF_PAR_LEAD = 2;
   localparam int DEF_INIT_LEN = 8;
   localparam int DEF_RUN_SKIP = 9;
   localparam int NRST_LEN     = 2;

endpackage

// File: rtl/lif_stim_sequencer_if.sv
// rtl/lif_stim_sequencer_if.sv - input-current byte stream handshake into the sequencer
interface lif_stim_sequencer_if;
   logic       cur_valid;
   logic [7:0] cur_data;
   logic       cur_ready;

   modport master (output cur_valid, output cur_data, input cur_ready);
   modport slave  (input cur_valid, input cur_data, output cur_ready);
endinterface

// File: rtl/lif_sample_capture.sv
// rtl/lif_sample_capture.sv - registers neuron voltage/spike pins, counts spikes, flags pin-direction faults
module lif_sample_capture (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        sample_en,
   input  logic [7:0]  nrn_uo,
   input  logic [7:0]  nrn_uio,
   input  logic        spike_oe,
   output logic        samp_valid,
   output logic [15:0] samp_v,
   output logic        samp_spike,
   output logic [15:0] spike_cnt,
   output logic        err
);

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_valid <= 1'b0;
         samp_v     <= 16'h0000;
         samp_spike <= 1'b0;
         spike_cnt  <= 16'h0000;
         err        <= 1'b0;
      end else begin
         samp_valid <= sample_en;
         if (sample_en) begin
            samp_v     <= {nrn_uo, nrn_uio[7:1], 1'b0};
            samp_spike <= nrn_uio[0];
         end
         // counter and fault flag move together with the sample they describe
         if (clear) begin
            spike_cnt <= 16'h0000;
            err       <= 1'b0;
         end else if (sample_en) begin
            if (nrn_uio[0] && (spike_cnt != 16'hFFFF))
               spike_cnt <= spike_cnt + 16'd1;
            if (!spike_oe)
               err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/lif_stim_sequencer.sv
// rtl/lif_stim_sequencer.sv - loads parameters and initial voltages into a LIF neuron, streams current, samples output
module lif_stim_sequencer
   import lif_pkg::*;
#(
   parameter int PAR_LEAD = DEF_PAR_LEAD,
   parameter int INIT_LEN = DEF_INIT_LEN,
   parameter int RUN_SKIP = DEF_RUN_SKIP
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [15:0]           e_rest,
   input  logic [15:0]           e_tau,
   input  logic [15:0]           v_th,
   input  logic                  vi_wr_en,
   input  logic [2:0]            vi_wr_addr,
   input  logic [15:0]           vi_wr_data,
   lif_stim_sequencer_if.slave   cur,
   output logic                  nrn_rst_n,
   output logic [7:0]            nrn_ui,
   output logic [7:0]            nrn_uio_drv,
   input  logic [7:0]            nrn_uo,
   input  logic [7:0]            nrn_uio,
   input  logic [7:0]            nrn_uio_oe,
   output logic                  samp_valid,
   output logic [15:0]           samp_v,
   output logic                  samp_spike,
   output logic [15:0]           spike_cnt,
   output logic                  busy,
   output logic                  err,
   output logic [2:0]            state_o
);

   localparam logic [3:0] NRST_LAST = 4'(NRST_LEN - 1);
   localparam logic [3:0] LEAD_LAST = 4'(PAR_LEAD - 1);
   localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
   localparam logic [3:0] SKIP      = 4'(RUN_SKIP);
   localparam logic [3:0] SKIP_LAST = 4'(RUN_SKIP - 1);

   lif_state_e  state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [3:0]  dcnt, dcnt_n;
   logic [15:0] e_rest_q, e_tau_q, v_th_q;
   logic [15:0] vi_tab [8];
   logic [15:0] word;
   logic        launch;
   logic        sample_en;
   logic        unused_oe;

   assign launch    = (state == ST_IDLE) && start;
   assign unused_oe = ^nrn_uio_oe[7:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         dcnt     <= 4'd0;
         e_rest_q <= 16'h0000;
         e_tau_q  <= 16'h0000;
         v_th_q   <= 16'h0000;
         for (int i = 0; i < 8; i++) vi_tab[i] <= 16'h0000;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dcnt  <= dcnt_n;
         if (launch) begin
            e_rest_q <= e_rest;
            e_tau_q  <= e_tau;
            v_th_q   <= v_th;
         end
         if ((state == ST_IDLE) && vi_wr_en)
            vi_tab[vi_wr_addr] <= vi_wr_data;
      end
   end

   // cnt is the per-phase index; in RUN/DRAIN it is the saturating RUN+DRAIN total
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dcnt_n  = dcnt;
      case (state)
         ST_IDLE: if (start) begin
            state_n = ST_NRST;
            cnt_n   = 4'd0;
         end
         ST_NRST: if (cnt == NRST_LAST) begin
            state_n = ST_LEAD;
            cnt_n   = 4'd0;
         end else cnt_n = cnt + 4'd1;
         ST_LEAD: if (cnt == LEAD_LAST) begin
            state_n = ST_PAR;
            cnt_n   = 4'd0;
         end else cnt_n = cnt + 4'd1;
         ST_PAR: if (cnt == 4'd2) begin
            state_n = ST_INIT;
            cnt_n   = 4'd0;
         end else cnt_n = cnt + 4'd1;
         ST_INIT: if (cnt == INIT_LAST) begin
            state_n = ST_RUN;
            cnt_n   = 4'd0;
         end else cnt_n = cnt + 4'd1;
         ST_RUN: begin
            if (cnt != 4'hF) cnt_n = cnt + 4'd1;
            if (stop) begin
               state_n = ST_DRAIN;
               dcnt_n  = 4'd0;
            end
         end
         ST_DRAIN: begin
            if (cnt != 4'hF) cnt_n = cnt + 4'd1;
            if (dcnt == SKIP_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = 4'd0;
               dcnt_n  = 4'd0;
            end else dcnt_n = dcnt + 4'd1;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
            dcnt_n  = 4'd0;
         end
      endcase
   end

   always_comb begin
      word          = 16'h0000;
      cur.cur_ready = 1'b0;
      case (state)
         ST_PAR:  word = (cnt == 4'd0) ? e_rest_q : (cnt == 4'd1) ? e_tau_q : v_th_q;
         ST_INIT: word = vi_tab[cnt[2:0]];
         ST_RUN: begin
            cur.cur_ready = 1'b1;
            if (cur.cur_valid) word = {cur.cur_data, 8'h00};
         end
         default: word = 16'h0000;
      endcase
   end

   assign nrn_ui      = word[15:8];
   assign nrn_uio_drv = word[7:0];
   assign nrn_rst_n   = !((state == ST_IDLE) || (state == ST_NRST));
   assign busy        = (state != ST_IDLE);
   assign state_o     = state;
   assign sample_en   = ((state == ST_RUN) || (state == ST_DRAIN)) && (cnt >= SKIP);

   lif_sample_capture u_capture (
      .clk        (clk),
      .rst        (rst),
      .clear      (launch),
      .sample_en  (sample_en),
      .nrn_uo     (nrn_uo),
      .nrn_uio    (nrn_uio),
      .spike_oe   (nrn_uio_oe[0]),
      .samp_valid (samp_valid),
      .samp_v     (samp_v),
      .samp_spike (samp_spike),
      .spike_cnt  (spike_cnt),
      .err        (err)
   );

endmodule

// File: tb/tb_lif_stim_sequencer.sv
// tb/tb_lif_stim_sequencer.sv - directed self-checking bench for lif_stim_sequencer
module tb_lif_stim_sequencer;
   import lif_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, stop;
   logic [15:0] e_rest, e_tau, v_th;
   logic        vi_wr_en;
   logic [2:0]  vi_wr_addr;
   logic [15:0] vi_wr_data;
   logic        nrn_rst_n;
   logic [7:0]  nrn_ui, nrn_uio_drv, nrn_uo, nrn_uio, nrn_uio_oe;
   logic        samp_valid, samp_spike, busy, err;
   logic [15:0] samp_v, spike_cnt;
   logic [2:0]  state_o;
   logic [15:0] tab_model [8];
   logic [7:0]  prev_uo, prev_uio;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   lif_stim_sequencer_if cur ();

   lif_stim_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .e_rest      (e_rest),
      .e_tau       (e_tau),
      .v_th        (v_th),
      .vi_wr_en    (vi_wr_en),
      .vi_wr_addr  (vi_wr_addr),
      .vi_wr_data  (vi_wr_data),
      .cur         (cur),
      .nrn_rst_n   (nrn_rst_n),
      .nrn_ui      (nrn_ui),
      .nrn_uio_drv (nrn_uio_drv),
      .nrn_uo      (nrn_uo),
      .nrn_uio     (nrn_uio),
      .nrn_uio_oe  (nrn_uio_oe),
      .samp_valid  (samp_valid),
      .samp_v      (samp_v),
      .samp_spike  (samp_spike),
      .spike_cnt   (spike_cnt),
      .busy        (busy),
      .err         (err),
      .state_o     (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pins(input int k, input bit spk);
      nrn_uo  = 8'(k * 3 + 1);
      nrn_uio = {7'(k + 64), spk};
   endtask

   // from an IDLE cycle: launch, walk NRST/LEAD/PAR/INIT, return in the last INIT cycle
   task automatic launch(input logic [15:0] er, input logic [15:0] et, input logic [15:0] vt);
      logic [15:0] par [3];
      par[0] = er; par[1] = et; par[2] = vt;
      start = 1'b1; e_rest = er; e_tau = et; v_th = vt;
      tick();
      start = 1'b0; e_rest = 16'hDEAD; e_tau = 16'hBEEF; v_th = 16'hCAFE;
      #1;
      check("nrst0_state", state_o, 1);
      check("nrst0_rst_n", nrn_rst_n, 0);
      check("nrst0_busy", busy, 1);
      check("launch_err_clr", err, 0);
      check("launch_cnt_clr", spike_cnt, 0);
      vi_wr_en = 1'b1; vi_wr_addr = 3'd3; vi_wr_data = 16'hFFFF; start = 1'b1;
      tick();
      vi_wr_en = 1'b0; start = 1'b0; stop = 1'b1;
      #1;
      check("nrst1_state", state_o, 1);
      check("nrst1_rst_n", nrn_rst_n, 0);
      tick();
      stop = 1'b0;
      #1;
      check("lead0_state", state_o, 2);
      check("lead0_rst_n", nrn_rst_n, 1);
      check("lead0_word", {nrn_ui, nrn_uio_drv}, 0);
      tick(); #1;
      check("lead1_state", state_o, 2);
      check("lead1_word", {nrn_ui, nrn_uio_drv}, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check("par_state", state_o, 3);
         check("par_word", {nrn_ui, nrn_uio_drv}, par[i]);
         check("par_ready", cur.cur_ready, 0);
      end
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         check("init_state", state_o, 4);
         check("init_word", {nrn_ui, nrn_uio_drv}, tab_model[i]);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      e_rest = 16'h0; e_tau = 16'h0; v_th = 16'h0;
      vi_wr_en = 1'b0; vi_wr_addr = 3'd0; vi_wr_data = 16'h0;
      cur.cur_valid = 1'b0; cur.cur_data = 8'h00;
      nrn_uo = 8'h00; nrn_uio = 8'h00; nrn_uio_oe = 8'hFF;
      prev_uo = 8'h00; prev_uio = 8'h00;
      for (int i = 0; i < 8; i++) tab_model[i] = 16'h0000;

      repeat (3) tick();
      rst = 1'b0;
      check("rst_state", state_o, 0);
      check("rst_rst_n", nrn_rst_n, 0);
      check("rst_busy", busy, 0);
      check("rst_word", {nrn_ui, nrn_uio_drv}, 0);
      check("rst_ready", cur.cur_ready, 0);
      check("rst_svalid", samp_valid, 0);
      check("rst_sv", samp_v, 0);
      check("rst_cnt", spike_cnt, 0);
      check("rst_err", err, 0);

      for (int i = 0; i < 8; i++) begin
         vi_wr_en = 1'b1; vi_wr_addr = 3'(i); vi_wr_data = 16'h0100 + 16'(i);
         tab_model[i] = 16'h0100 + 16'(i);
         tick();
      end
      vi_wr_en = 1'b0;

      // run 1: continuous current, spike every 5th sample, oe fault, long stop
      launch(16'hC400, 16'h018E, 16'h3C00);
      for (int k = 0; k < 30; k++) begin
         bit spk;
         tick();
         spk = (k >= 9) && (((k - 9) % 5) == 4);
         drive_pins(k, spk);
         if (k == 13) begin nrn_uo = 8'hAB; nrn_uio = 8'hCD; end
         nrn_uio_oe    = (k == 20) ? 8'h00 : 8'hFF;
         cur.cur_valid = (k != 17);
         cur.cur_data  = 8'h20;
         stop          = (k == 29);
         #1;
         check("run_state", state_o, 5);
         check("run_ready", cur.cur_ready, 1);
         check("run_ui", nrn_ui, (k == 17) ? 8'h00 : 8'h20);
         check("run_uio_drv", nrn_uio_drv, 0);
         check("run_svalid", samp_valid, (k >= 10));
         if (k >= 10) begin
            check("run_sv", samp_v, {prev_uo, prev_uio[7:1], 1'b0});
            check("run_spike", samp_spike, prev_uio[0]);
         end
         if (k == 14) begin
            check("pin_sv_abcc", samp_v, 16'hABCC);
            check("pin_spike_cd", samp_spike, 1);
         end
         check("run_err", err, (k >= 21));
         prev_uo = nrn_uo; prev_uio = nrn_uio;
      end
      check("cnt_20samples", spike_cnt, 4);

      for (int d = 0; d < 9; d++) begin
         int k;
         k = 30 + d;
         tick();
         stop = 1'b0;
         drive_pins(k, ((k - 9) % 5) == 4);
         #1;
         check("drain_state", state_o, 6);
         check("drain_ui", nrn_ui, 0);
         check("drain_ready", cur.cur_ready, 0);
         check("drain_svalid", samp_valid, 1);
         check("drain_sv", samp_v, {prev_uo, prev_uio[7:1], 1'b0});
         check("drain_err", err, 1);
         prev_uo = nrn_uo; prev_uio = nrn_uio;
      end
      tick(); #1;
      check("end1_state", state_o, 0);
      check("end1_busy", busy, 0);
      check("end1_svalid", samp_valid, 1);
      check("end1_cnt", spike_cnt, 6);
      check("end1_rst_n", nrn_rst_n, 0);
      tick(); #1;
      check("idle_svalid", samp_valid, 0);
      check("idle_err_held", err, 1);

      // run 2: early stop on RUN cycle 3
      launch(16'h1111, 16'h2222, 16'h3333);
      for (int t = 0; t < 14; t++) begin
         int exp_st;
         tick();
         stop = (t == 3);
         drive_pins(t, 1'b0);
         #1;
         exp_st = (t < 4) ? 5 : (t < 13) ? 6 : 0;
         check("early_state", state_o, exp_st);
         check("early_svalid", samp_valid, (t >= 10));
      end
      stop = 1'b0;
      tick(); #1;
      check("early_idle_svalid", samp_valid, 0);

      // run 3: reset mid-RUN while sampling
      launch(16'h0A0A, 16'h0B0B, 16'h0C0C);
      for (int k = 0; k < 13; k++) begin
         tick();
         drive_pins(k, 1'b0);
         #1;
      end
      check("pre_abort_svalid", samp_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_state", state_o, 0);
      check("abort_svalid", samp_valid, 0);
      check("abort_ready", cur.cur_ready, 0);
      check("abort_rst_n", nrn_rst_n, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check("abort_quiet", samp_valid, 0);
      end

      // table must have been cleared by that reset
      for (int i = 0; i < 8; i++) tab_model[i] = 16'h0000;
      launch(16'h0001, 16'h0002, 16'h0003);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lif_stim_sequencer.md
LIF_STIM_SEQUENCER -- requirements
Module: lif_stim_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PAR_LEAD, 2: cycles after neuron reset release before the first parameter word.
- INIT_LEN, 8: number of initial-voltage words.
- RUN_SKIP, 9: run cycles discarded before the first valid sample (neuron pipeline depth).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle launch pulse; ignored unless IDLE.
- stop, in, 1: ends RUN.
- e_rest, in, 16: rest potential, sampled at start.
- e_tau, in, 16: leak factor, sampled at start.
- v_th, in, 16: threshold, sampled at start.
- vi_wr_en, in, 1: write strobe for the initial-voltage table.
- vi_wr_addr, in, 3: table index.
- vi_wr_data, in, 16: table word.
- cur_valid, in, 1: current-stream valid.
- cur_data, in, 8: current byte.
- cur_ready, out, 1: current-stream ready.
- nrn_rst_n, out, 1: neuron reset; 0 resets the neuron.
- nrn_ui, out, 8: drives the neuron dedicated inputs (word high byte).
- nrn_uio_drv, out, 8: drives the neuron bidirectional inputs (word low byte).
- nrn_uo, in, 8: neuron dedicated outputs (vout[15:8]).
- nrn_uio, in, 8: neuron bidirectional outputs ({vout[7:1], spike}).
- nrn_uio_oe, in, 8: neuron IO direction.
- samp_valid, out, 1: sample strobe.
- samp_v, out, 16: captured membrane voltage.
- samp_spike, out, 1: captured spike.
- spike_cnt, out, 16: saturating spike count.
- busy, out, 1: high whenever state is not IDLE.
- err, out, 1: sticky direction fault.
- state_o, out, 3: current state encoding.

Function
REQ-003 The FSM SHALL have states IDLE=0, NRST=1, LEAD=2, PAR=3, INIT=4, RUN=5, DRAIN=6.
REQ-004 IDLE SHALL go to NRST on start. start SHALL latch e_rest, e_tau and v_th, clear spike_cnt and clear err.
REQ-005 NRST SHALL hold nrn_rst_n=0 for exactly 2 cycles, then go to LEAD. nrn_rst_n SHALL be 1 in all other states except IDLE.
REQ-006 LEAD SHALL drive nrn_ui and nrn_uio_drv to 0 for PAR_LEAD cycles, then go to PAR.
REQ-007 PAR SHALL present one word per cycle as {nrn_ui, nrn_uio_drv}, in the order e_rest, e_tau, v_th (3 cycles), then go to INIT.
REQ-008 INIT SHALL present table entries 0..INIT_LEN-1, one per cycle, then go to RUN.
REQ-009 In RUN, cur_ready SHALL be 1.
- A cur_valid&cur_ready cycle drives nrn_ui=cur_data; a cycle with cur_valid=0 drives nrn_ui=0.
- nrn_uio_drv SHALL be 0 in RUN.
- cur_ready SHALL be 0 in every other state.
REQ-010 RUN SHALL count cycles with a 4-bit counter; the first RUN_SKIP cycles produce no sample.
REQ-011 From RUN cycle RUN_SKIP onward, samp_valid SHALL pulse every cycle with samp_v={nrn_uo, nrn_uio[7:1], 1'b0} and samp_spike=nrn_uio[0], registered, so they appear 1 cycle after the pins.
REQ-012 spike_cnt SHALL increment on each samp_valid with samp_spike=1 and saturate at 16'hFFFF.
REQ-013 stop in RUN SHALL go to DRAIN. DRAIN SHALL keep sampling for RUN_SKIP cycles with nrn_ui=0, then go to IDLE.
REQ-014 stop in any state other than RUN SHALL be ignored. start while busy SHALL be ignored.
REQ-015 A vi_wr_en write SHALL update the table only while IDLE; writes while busy SHALL be dropped.
REQ-016 err SHALL set (sticky until the next start) when nrn_uio_oe[0]=0 on any sampling cycle.
REQ-017 If stop arrives before RUN_SKIP elapses, DRAIN SHALL still last RUN_SKIP cycles, and sampling SHALL begin only once the RUN+DRAIN cycle total reaches RUN_SKIP.

Reset
REQ-018 rst SHALL force the following, and take priority over start and stop in the same cycle:
- state IDLE;
- nrn_rst_n=0;
- nrn_ui=0, nrn_uio_drv=0;
- cur_ready=0, samp_valid=0, samp_v=0, samp_spike=0;
- spike_cnt=0, err=0, busy=0;
- all counters 0.
REQ-019 The table contents SHALL be cleared to 0 by rst.
REQ-020 rst asserted mid-RUN SHALL abort with no further samp_valid pulse.

Structure
REQ-021 The state encoding, the default parameter values and the NRST length (2) SHALL live in a shared package, lif_pkg.
REQ-022 The sampling/counting logic SHALL be one sub-module, lif_sample_capture, holding samp_*, spike_cnt and err; everything else SHALL be in the top level.

Verification
REQ-023 Reset and launch: rst for 3 cycles, then start with e_rest=0xC400, e_tau=0x018E, v_th=0x3C00.
- nrn_rst_n low for 2 cycles.
- {ui,uio} = 0xC400, 0x018E, 0x3C00 on 3 consecutive cycles after 2 lead cycles.
REQ-024 Table 0x0100..0x0107 written in IDLE -> INIT presents 0x0100..0x0107 in order. A write of 0xFFFF while busy never appears.
REQ-025 RUN with cur_data=0x20 continuous, neuron model spiking every 5th sample:
- first samp_valid on RUN cycle 10;
- spike_cnt=4 after 20 samples.
REQ-026 Pin value nrn_uo=0xAB, nrn_uio=0xCD -> samp_v=0xABCC, samp_spike=1.
REQ-027 stop on RUN cycle 3 -> DRAIN lasts 9 cycles, sampling resumes at RUN+DRAIN cycle 9, then IDLE. rst mid-RUN -> IDLE next cycle with no further samp_valid.
REQ-028 nrn_uio_oe=0 during RUN -> err=1 held until the next start.
